// File: rtl/aes_key_streamer_pkg.sv
// Shared definitions for the AES key streamer: key geometry and FSM state encoding.
package aes_package;

   localparam int unsigned KEY_WORDS  = 4;
   localparam int unsigned WORD_IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      REPLAY = 2'd2
   } keystr_state_t;

endpackage

// File: rtl/aes_key_streamer.sv
// Loads a 128-bit key as four 32-bit words and replays it once per block
// towards the AES engine; the stored key survives jobs so it can be reused.
module aes_key_streamer
   import aes_package::*;
#(
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic                    reuse_key_i,
   input  logic [CNT_WIDTH-1:0]    nb_blocks_i,
   input  logic                    key_i_valid,
   input  logic [DATA_WIDTH-1:0]   key_i_data,
   output logic                    key_i_ready,
   output logic                    key_o_valid,
   output logic [DATA_WIDTH-1:0]   key_o_data,
   output logic [DATA_WIDTH/8-1:0] key_o_strb,
   input  logic                    key_o_ready,
   output logic                    busy_o,
   output logic                    done_o
);

   keystr_state_t         state_r;
   keystr_state_t         state_nxt_s;
   logic [WORD_IDX_W-1:0] word_cnt_r;
   logic [CNT_WIDTH-1:0]  block_cnt_r;
   logic [CNT_WIDTH-1:0]  nb_blocks_r;
   logic [DATA_WIDTH-1:0] key_reg_r [KEY_WORDS];
   logic                  done_r;
   logic                  done_set_s;
   logic                  in_hs_s;
   logic                  out_hs_s;
   logic                  last_word_s;
   logic                  last_block_s;
   logic                  start_job_s;
   logic                  start_empty_s;

   assign in_hs_s       = (state_r == LOAD) && key_i_valid;
   assign out_hs_s      = (state_r == REPLAY) && key_o_ready;
   assign last_word_s   = (word_cnt_r == WORD_IDX_W'(KEY_WORDS - 1));
   // block_cnt never exceeds nb_blocks-1, so the maximum job cannot overflow it
   assign last_block_s  = (block_cnt_r == (nb_blocks_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1}));
   assign start_job_s   = start_i && (state_r == IDLE) && (nb_blocks_i != {CNT_WIDTH{1'b0}});
   assign start_empty_s = start_i && (state_r == IDLE) && (nb_blocks_i == {CNT_WIDTH{1'b0}});

   // Next-state and completion decode.
   always_comb begin
      state_nxt_s = state_r;
      done_set_s  = 1'b0;
      case (state_r)
         IDLE: begin
            done_set_s = start_empty_s;
            if (start_job_s) begin
               if (reuse_key_i) begin
                  state_nxt_s = REPLAY;
               end else begin
                  state_nxt_s = LOAD;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            if (in_hs_s && last_word_s) begin
               state_nxt_s = REPLAY;
            end else begin
               state_nxt_s = LOAD;
            end
         end
         REPLAY: begin
            if (out_hs_s && last_word_s && last_block_s) begin
               state_nxt_s = IDLE;
               done_set_s  = 1'b1;
            end else begin
               state_nxt_s = REPLAY;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, counters, key storage and done pulse; clear_i outranks everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         word_cnt_r  <= {WORD_IDX_W{1'b0}};
         block_cnt_r <= {CNT_WIDTH{1'b0}};
         nb_blocks_r <= {CNT_WIDTH{1'b0}};
         done_r      <= 1'b0;
         for (int i = 0; i < KEY_WORDS; i++) begin
            key_reg_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (clear_i) begin
         state_r     <= IDLE;
         word_cnt_r  <= {WORD_IDX_W{1'b0}};
         block_cnt_r <= {CNT_WIDTH{1'b0}};
         done_r      <= 1'b0;
         for (int i = 0; i < KEY_WORDS; i++) begin
            key_reg_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         state_r <= state_nxt_s;
         done_r  <= done_set_s;
         case (state_r)
            IDLE: begin
               if (start_job_s) begin
                  nb_blocks_r <= nb_blocks_i;
                  word_cnt_r  <= {WORD_IDX_W{1'b0}};
                  block_cnt_r <= {CNT_WIDTH{1'b0}};
               end
            end
            LOAD: begin
               if (in_hs_s) begin
                  key_reg_r[word_cnt_r] <= key_i_data;
                  word_cnt_r            <= word_cnt_r + {{(WORD_IDX_W-1){1'b0}}, 1'b1};
                  block_cnt_r           <= {CNT_WIDTH{1'b0}};
               end
            end
            REPLAY: begin
               if (out_hs_s) begin
                  word_cnt_r <= word_cnt_r + {{(WORD_IDX_W-1){1'b0}}, 1'b1};
                  if (last_word_s) begin
                     block_cnt_r <= block_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // All outputs decode registered state only; valid never depends on key_o_ready.
   assign key_i_ready = (state_r == LOAD);
   assign key_o_valid = (state_r == REPLAY);
   assign key_o_data  = key_o_valid ? key_reg_r[word_cnt_r] : {DATA_WIDTH{1'b0}};
   assign key_o_strb  = {(DATA_WIDTH/8){key_o_valid}};
   assign busy_o      = (state_r != IDLE);
   assign done_o      = done_r;

endmodule

// File: doc/aes_key_streamer.md
AES_KEY_STREAMER -- requirements
Module: aes_key_streamer

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the block counter.
REQ-002 Parameter DATA_WIDTH, default 32: key word width (fixed at 32).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low. Ports clk_i and rst_ni come first.
REQ-004 clk_i  input  1  clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 clear_i  input  1  synchronous soft clear.
REQ-007 start_i  input  1  single-cycle start pulse.
REQ-008 reuse_key_i  input  1  sampled with start_i; 1 means skip load and replay the stored key.
REQ-009 nb_blocks_i  input  CNT_WIDTH  number of 128-bit blocks to serve, sampled with start_i.
REQ-010 key_i  hwpe_stream_intf_stream.sink  32  key words, most significant word first.
REQ-011 key_o  hwpe_stream_intf_stream.source  32  key stream feeding the AES engine key input.
REQ-012 busy_o  output  1  high whenever state is not IDLE.
REQ-013 done_o  output  1  registered one-cycle pulse at completion.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD and REPLAY.
REQ-015 In IDLE, key_i.ready=0 and key_o.valid=0.
REQ-016 In IDLE, start_i with nb_blocks_i==0 SHALL stay in IDLE and pulse done_o in the next cycle.
REQ-017 In IDLE, start_i with nb_blocks_i!=0 and reuse_key_i=0 SHALL latch nb_blocks and enter LOAD.
REQ-018 In IDLE, start_i with nb_blocks_i!=0 and reuse_key_i=1 SHALL latch nb_blocks and enter REPLAY directly.
REQ-019 In LOAD, key_i.ready=1; each key_i handshake SHALL write key_reg[word_cnt] and increment word_cnt (0..3).
REQ-020 On the 4th LOAD handshake the FSM SHALL enter REPLAY with word_cnt=0 and block_cnt=0. key_o.valid SHALL rise the following cycle (latency 1).
REQ-021 In REPLAY, key_o.valid=1, key_o.data=key_reg[word_cnt] and key_o.strb='1; key_i.ready=0.
REQ-022 key_o.valid SHALL be driven only from registered state and SHALL have no combinational dependency on key_o.ready.
REQ-023 key_o.valid and key_o.data SHALL stay stable until a handshake completes.
REQ-024 Each key_o handshake SHALL advance word_cnt, wrapping 3->0. Each wrap SHALL increment block_cnt.
REQ-025 When the handshake of word 3 occurs with block_cnt==nb_blocks-1, the FSM SHALL return to IDLE and pulse done_o for exactly one cycle.
REQ-026 Throughput SHALL be 1 word per cycle with key_o.ready held high, i.e. 4*nb_blocks cycles in REPLAY.
REQ-027 start_i outside IDLE SHALL be ignored.
REQ-028 clear_i SHALL have priority over all other inputs.
REQ-029 clear_i in any state SHALL, on the next edge, force IDLE, zero word_cnt, block_cnt and key_reg, and suppress done_o.
REQ-030 key_reg SHALL persist across completed jobs, so that reuse_key_i replays the last loaded key.
REQ-031 nb_blocks=2^CNT_WIDTH-1 SHALL complete without counter overflow.

Reset
REQ-032 rst_ni low SHALL asynchronously force state=IDLE and zero word_cnt, block_cnt, nb_blocks and key_reg.
REQ-033 Under reset, key_o.valid=0, key_o.data=0, key_i.ready=0, busy_o=0 and done_o=0.
REQ-034 Reset asserted mid-LOAD or mid-REPLAY SHALL abort the job, with no done_o pulse.

Structure
REQ-035 The shared package aes_package SHALL hold KEY_WORDS=4 and the state enum keystr_state_t {IDLE, LOAD, REPLAY}.
REQ-036 The block SHALL be a single module with no sub-module; the key storage is a 4x32 register array inside it.

Verification
REQ-037 Load key 2b7e1516/28aed2a6/abf71588/09cf4f3c, nb_blocks=4, key_o.ready=1 -> key_o emits 16 words, that 4-word pattern repeated 4 times on consecutive cycles; done_o pulses once, one cycle after the last handshake.
REQ-038 Same key, nb_blocks=2, key_o.ready toggling 1,0,1,0 -> 8 words in order, data stable while ready=0, done_o pulses once.
REQ-039 After REQ-037, start with reuse_key_i=1 and nb_blocks=1 -> no key_i.ready, 4 words 2b7e1516..09cf4f3c on key_o.
REQ-040 start with nb_blocks=0 -> busy_o stays 0, done_o pulses the next cycle, key_o.valid stays 0.
REQ-041 clear_i after 6 of 16 words -> next cycle IDLE, key_o.valid=0, no done_o; a following reuse_key start emits 00000000 words.
REQ-042 rst_ni low mid-LOAD after 2 words -> all outputs 0; a fresh full load then replays correctly.
